// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO-to-stream reader.
// Default data width, default packet length, beat-counter width,
// buffer occupancy encoding and the beat-counter advance function.
package fifo_rd_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_PKT_LEN = 4;
   localparam int BEAT_W      = 16;

   typedef logic [BEAT_W-1:0] beat_t;

   typedef enum logic [1:0] {
      OCC_ZERO = 2'd0,
      OCC_ONE  = 2'd1,
      OCC_TWO  = 2'd2
   } occ_e;

   // Advance the beat counter, wrapping to zero after the final word of a packet.
   function automatic beat_t beat_next(input beat_t beat, input beat_t last_beat);
      if (beat == last_beat) begin
         beat_next = {BEAT_W{1'b0}};
      end else begin
         beat_next = beat + {{(BEAT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order buffer between the FIFO capture path and the stream output.
// Entry 0 always holds the oldest word and drives out_data directly, so the
// output stays stable while the consumer stalls. Reset discards any capture
// arriving in the same cycle.
module stream_skid2
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occ
);

   occ_e             occ_q, occ_d;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic             pop_s;

   assign out_valid = !rst && (occ_q != OCC_ZERO);
   assign out_data  = buf0_q;
   assign occ       = occ_q;
   assign pop_s     = out_valid && out_ready;

   // Next buffer contents from the capture/pop combination for each occupancy.
   always_comb begin
      occ_d  = occ_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      case (occ_q)
         OCC_ZERO: begin
            if (in_valid) begin
               buf0_d = in_data;
               occ_d  = OCC_ONE;
            end else begin
               occ_d  = OCC_ZERO;
            end
         end
         OCC_ONE: begin
            if (pop_s && in_valid) begin
               buf0_d = in_data;
            end else if (pop_s) begin
               occ_d  = OCC_ZERO;
            end else if (in_valid) begin
               buf1_d = in_data;
               occ_d  = OCC_TWO;
            end else begin
               occ_d  = OCC_ONE;
            end
         end
         OCC_TWO: begin
            if (pop_s && in_valid) begin
               buf0_d = buf1_q;
               buf1_d = in_data;
            end else if (pop_s) begin
               buf0_d = buf1_q;
               occ_d  = OCC_ONE;
            end else begin
               occ_d  = OCC_TWO;
            end
         end
         default: begin
            occ_d = OCC_ZERO;
         end
      endcase
   end

   // Buffer state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q  <= OCC_ZERO;
         buf0_q <= {WIDTH{1'b0}};
         buf1_q <= {WIDTH{1'b0}};
      end else begin
         occ_q  <= occ_d;
         buf0_q <= buf0_d;
         buf1_q <= buf1_d;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from an upstream synchronous FIFO (one-cycle read latency)
// and presents them as a valid/ready stream with packet framing (m_last).
// Reads are issued only when the word can be guaranteed a buffer slot.
// Optional feature: define FIFO_STREAM_READER_PKTCNT_EN to add the
// pkt_count output counting completed packets.
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PKT_LEN = DEF_PKT_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_data,
`ifdef FIFO_STREAM_READER_PKTCNT_EN
   output logic [15:0]      pkt_count,
`endif
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
);

   localparam beat_t LAST_BEAT = beat_t'(PKT_LEN - 1);

   logic       inflight_q, inflight_d;
   beat_t      beat_q, beat_d;
   logic [1:0] occ_s;
   logic [2:0] pending_s;
   logic       pop_s;

   assign pop_s  = m_valid && m_ready;
   assign m_last = m_valid && (beat_q == LAST_BEAT);

   stream_skid2 #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight_q),
      .in_data   (fifo_data),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_data),
      .occ       (occ_s)
   );

   // Issue a read only if the word will still find a free slot when it lands.
   always_comb begin
      pending_s  = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
      fifo_rd_en = !rst && !fifo_empty && (pending_s < 3'd2);
      inflight_d = fifo_rd_en;
      if (pop_s) begin
         beat_d = beat_next(beat_q, LAST_BEAT);
      end else begin
         beat_d = beat_q;
      end
   end

   // In-flight read flag and beat position within the current packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         beat_q     <= {BEAT_W{1'b0}};
      end else begin
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
      end
   end

`ifdef FIFO_STREAM_READER_PKTCNT_EN
   logic [15:0] pkt_count_q, pkt_count_d;

   assign pkt_count = pkt_count_q;

   // Count packets whose final word has been accepted downstream.
   always_comb begin
      if (pop_s && m_last) begin
         pkt_count_d = pkt_count_q + 16'd1;
      end else begin
         pkt_count_d = pkt_count_q;
      end
   end

   // Completed-packet counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count_q <= 16'd0;
      end else begin
         pkt_count_q <= pkt_count_d;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: stimulus pushes expected
// words into a queue, a negedge monitor pops and compares each accepted beat.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_data = 8'h00;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;
`ifdef FIFO_STREAM_READER_PKTCNT_EN
   logic [15:0] pkt_count;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         vectors = 0;
   int         miscompares = 0;

   fifo_stream_reader #(
      .WIDTH   (8),
      .PKT_LEN (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
`ifdef FIFO_STREAM_READER_PKTCNT_EN
      .pkt_count  (pkt_count),
`endif
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last)
   );

   always #5 clk = ~clk;

   // Upstream synchronous FIFO model: registered read data, one-cycle latency.
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Monitor: every accepted beat must match the oldest expected word.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_extra: got %0h want none", m_data);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", {24'd0, m_data}, {24'd0, e.data});
            check("sb_last", {31'd0, m_last}, {31'd0, e.last});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] d, input logic last, input logic expect_out);
      exp_t e;
      mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 1;
      if (expect_out) begin
         e.data = d;
         e.last = last;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(input int max_cycles, input string name);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check(name, exp_q.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] t2_data [0:7] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
   logic [7:0] t2_last       = 8'b1000_1000;
   logic [7:0] t4_data [0:2] = '{8'h31, 8'h32, 8'h33};

   initial begin
      int base;
      bit seen;
      rst     = 1'b1;
      m_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check("rst_valid", {31'd0, m_valid}, 32'd0);
      check("rst_rden",  {31'd0, fifo_rd_en}, 32'd0);
      check("rst_last",  {31'd0, m_last}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_data", {24'd0, m_data}, 32'd0);

      // Empty FIFO: nothing is read or presented.
      for (int c = 0; c < 10; c++) begin
         step();
         @(negedge clk);
         check("idle_rden",  {31'd0, fifo_rd_en}, 32'd0);
         check("idle_valid", {31'd0, m_valid}, 32'd0);
      end

      // Back-to-back burst 0x11..0x18, last on 0x14 and 0x18.
      step();
      for (int i = 0; i < 8; i++) load(t2_data[i], t2_last[i], 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("burst_start", {31'd0, seen}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         check("burst_valid", {31'd0, m_valid}, 32'd1);
         check("burst_data", {24'd0, m_data}, {24'd0, t2_data[k]});
         @(negedge clk);
      end
      step();
      drain(10, "burst_drain");
      check("burst_fifo_empty", {31'd0, fifo_empty}, 32'd1);

      // Downstream stall: only two reads accepted, head word held steady.
      m_ready = 1'b0;
      base = rd_ptr;
      for (int i = 0; i < 8; i++) load(t2_data[i], t2_last[i], 1'b1);
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         if (m_valid) check("hold_data", {24'd0, m_data}, 32'h11);
      end
      check("hold_reads", rd_ptr - base, 32'd2);
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      step();
      m_ready = 1'b1;
      drain(30, "hold_drain");

      // Toggling ready with only three words available; FIFO runs dry mid-packet.
      for (int i = 0; i < 3; i++) load(t4_data[i], 1'b0, 1'b1);
      for (int c = 0; c < 40; c++) begin
         if (exp_q.size() == 0) break;
         m_ready = (c % 2 == 0);
         step();
      end
      check("toggle_drain", exp_q.size(), 32'd0);
      m_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      check("toggle_beat",  {16'd0, dut.beat_q}, 32'd3);
      check("toggle_valid", {31'd0, m_valid}, 32'd0);
      check("toggle_rden",  {31'd0, fifo_rd_en}, 32'd0);

      // Reset right after an accepted read: the word must be dropped.
      step();
      load(8'hAA, 1'b0, 1'b0);
      step();
      check("rst_rd_accepted", rd_ptr, wr_ptr);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_after_valid", {31'd0, m_valid}, 32'd0);
      check("rst_after_beat",  {16'd0, dut.beat_q}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         step();
         @(negedge clk);
         check("rst_no_aa", {31'd0, m_valid}, 32'd0);
      end

      // Three full packets of four words each.
      step();
      for (int i = 0; i < 12; i++) load(8'h41 + 8'(i), (i % 4 == 3), 1'b1);
      drain(40, "pkt_drain");
      repeat (2) step();
      @(negedge clk);
      check("end_last", {31'd0, m_last}, 32'd0);
`ifdef FIFO_STREAM_READER_PKTCNT_EN
      check("pkt_count", {16'd0, pkt_count}, 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
